// File: rtl/down_fir_pkg.sv
// Shared types and default sizing for the 88.2k->44.1k decimation FIR sequencer.
package down_fir_pkg;

  localparam int DOWN_NTAP    = 126;
  localparam int DOWN_MAC_LAT = 1;
  localparam int DOWN_ADDR_W  = 7;

  typedef enum logic [2:0] {
    S_FILL,
    S_SHIFT,
    S_MAC,
    S_FLUSH,
    S_OUT
  } down_seq_state_t;

endpackage

// File: rtl/down_fir_stall_cnt.sv
// Saturating count of output-stall cycles plus a sticky flag raised when the count reaches 255.
module down_fir_stall_cnt (
  input  logic       bck882,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] cnt,
  output logic       ovf
);

  always_ff @(posedge bck882 or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= 8'd0;
      ovf <= 1'b0;
    end else if (inc && cnt != 8'hFF) begin
      cnt <= cnt + 8'd1;
      // Flag goes up on the same edge the count lands on 255.
      if (cnt == 8'hFE) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/down_fir_seq.sv
// Frame sequencer for the decimation FIR: two-pair fill, history shift, NTAP MAC steps, flush, output handshake.
// Optional output-stall counter is built when DOWN_FIR_SEQ_STALL_EN is defined.
module down_fir_seq
  import down_fir_pkg::*;
#(
  parameter int NTAP    = DOWN_NTAP,
  parameter int MAC_LAT = DOWN_MAC_LAT,
  parameter int ADDR_W  = DOWN_ADDR_W
) (
  input  logic              bck882,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              mode_882,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              load_sel,
  output logic              shift_en,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              use_882,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef DOWN_FIR_SEQ_STALL_EN
  ,
  input  logic              stall_clr,
  output logic [7:0]        stall_cnt,
  output logic              stall_ovf
`endif
);

  localparam int FL_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [FL_W-1:0]   FL_LAST = FL_W'(MAC_LAT - 1);
  localparam logic [ADDR_W-1:0] K_LAST  = ADDR_W'(NTAP - 1);

  down_seq_state_t   state;
  logic              fill_cnt;
  logic              run_q;
  logic [ADDR_W-1:0] k;
  logic [FL_W-1:0]   fl_cnt;
  logic              accept;

  // run_q keeps in_ready low for the first cycle after reset release.
  assign in_ready = (state == S_FILL) & enable & run_q;
  assign load_sel = (state == S_FILL) & fill_cnt;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge bck882 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_FILL;
      fill_cnt  <= 1'b0;
      run_q     <= 1'b0;
      k         <= '0;
      fl_cnt    <= '0;
      shift_en  <= 1'b0;
      rom_addr  <= '0;
      use_882   <= 1'b0;
      mac_en    <= 1'b0;
      acc_clr   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        S_FILL: begin
          if (accept) begin
            fill_cnt <= ~fill_cnt;
            if (fill_cnt) begin
              state    <= S_SHIFT;
              shift_en <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        S_SHIFT: begin
          shift_en <= 1'b0;
          use_882  <= mode_882;
          k        <= '0;
          rom_addr <= '0;
          mac_en   <= 1'b1;
          acc_clr  <= 1'b1;
          state    <= S_MAC;
        end
        S_MAC: begin
          acc_clr <= 1'b0;
          if (k == K_LAST) begin
            mac_en <= 1'b0;
            fl_cnt <= '0;
            state  <= S_FLUSH;
          end else begin
            k        <= k + 1'b1;
            rom_addr <= k + 1'b1;
          end
        end
        S_FLUSH: begin
          if (fl_cnt == FL_LAST) begin
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            fill_cnt  <= 1'b0;
            state     <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

`ifdef DOWN_FIR_SEQ_STALL_EN
  down_fir_stall_cnt u_stall (
    .bck882  (bck882),
    .reset_n (reset_n),
    .inc     (out_valid & ~out_ready),
    .clr     (stall_clr),
    .cnt     (stall_cnt),
    .ovf     (stall_ovf)
  );
`endif

endmodule

// File: doc/down_fir_seq.md
# down_fir_seq

Sequencer for the 88.2k→44.1k stereo decimation FIR. It runs on the 88.2k bit clock and accepts two stereo input pairs per output frame through a valid/ready handshake. It commits them to the FIR history, then steps the shared coefficient ROM and MAC through all taps. It presents one stereo output sample per frame under a valid/ready handshake. It replaces the free-running 7-bit frame counter in the FIR datapath with explicit control strobes.

## Interface
- NTAP, 126, taps per output sample; rom_addr runs 0..NTAP-1
- MAC_LAT, 1, cycles from the last mac_en to the accumulator result being final
- ADDR_W, 7, rom_addr width; must satisfy 2^ADDR_W ≥ NTAP
- bck882  in  1  88.2k bit clock, all logic on posedge
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  permits new frames to start
- mode_882  in  1  coefficient bank request
- in_valid  in  1  upstream stereo pair available
- in_ready  out  1  sequencer accepts the pair this cycle
- load_sel  out  1  history slot for the accepted pair: 0 = older, 1 = newer
- shift_en  out  1  one-cycle pulse: shift the history by 2 and commit both loaded pairs
- rom_addr  out  ADDR_W  tap index to the ROM and history read port
- use_882  out  1  bank select to the ROM, frozen per frame
- mac_en  out  1  accumulate product this cycle
- acc_clr  out  1  load the product instead of accumulating (first tap)
- out_valid  out  1  final_l/final_r hold a new frame result
- out_ready  in  1  downstream takes the result
- busy  out  1  state ≠ S_FILL

## Operation
- States: S_FILL, S_SHIFT, S_MAC, S_FLUSH, S_OUT.
- S_FILL:
  - in_ready = enable & run_q. run_q is a flop reset to 0 and set on the first edge after reset release.
  - Each handshake (in_valid & in_ready) toggles the fill count.
  - load_sel equals the fill count during the handshake cycle.
  - The second handshake moves to S_SHIFT.
- S_SHIFT:
  - One cycle with shift_en = 1.
  - mode_882 is latched into use_882.
  - Tap counter k is cleared. Next state is S_MAC.
- S_MAC:
  - rom_addr = k, mac_en = 1, acc_clr = (k == 0), k increments each cycle.
  - At k == NTAP-1, move to S_FLUSH.
- S_FLUSH: MAC_LAT cycles with mac_en = 0, then move to S_OUT.
- S_OUT:
  - out_valid = 1 and is held until out_ready is sampled high.
  - The next state is then S_FILL with the fill count reset to 0.
- enable low:
  - Blocks only S_FILL acceptance; a frame in progress always completes.
  - If enable drops between the two pairs, the first pair is kept and the fill count holds.
- mode_882 changes outside S_SHIFT have no effect until the next frame.
- in_valid while in_ready = 0 is ignored; upstream holds its data.
- out_ready while out_valid = 0 is ignored.

## Timing
- Reset values:
  - state S_FILL, fill count 0, k 0, run_q 0
  - all outputs 0, including in_ready, rom_addr and use_882
- Reset mid-frame aborts immediately to the reset values. Partial sums are discarded by the datapath on its own reset.
- Second handshake at edge T:
  - shift_en high in cycle T+1.
  - mac_en high in cycles T+2 .. T+1+NTAP, with rom_addr 0..NTAP-1 in order.
  - out_valid rises at T+2+NTAP+MAC_LAT, which is T+129 at defaults.
- out_ready already high when out_valid rises: out_valid is high exactly one cycle and in_ready is available in the following cycle.
- Minimum frame is NTAP+MAC_LAT+4 cycles: 2 fill, 1 shift, NTAP MAC, MAC_LAT flush, 1 out. This is 131 at defaults and lies within the 128×2 bit-clock budget per 44.1k sample.
- rom_addr holds NTAP-1 outside S_MAC after the first frame; it is 0 only from reset.

## Configuration
- DOWN_FIR_SEQ_STALL_EN defined adds:
  - an 8-bit saturating counter stall_cnt, incremented each cycle with out_valid & ~out_ready;
  - an input stall_clr, which clears the counter synchronously;
  - a sticky flag stall_ovf, set when the counter reaches 255 and cleared by stall_clr.
- DOWN_FIR_SEQ_STALL_EN undefined: the ports, counter and flag are absent and the behaviour is otherwise identical.

## Structure
- Package down_fir_pkg:
  - state enum down_seq_state_t;
  - default localparams DOWN_NTAP = 126, DOWN_MAC_LAT = 1, DOWN_ADDR_W = 7.
- Optional sub-module down_fir_stall_cnt: the saturating counter and sticky flag. It is instantiated only under DOWN_FIR_SEQ_STALL_EN.
- FSM, fill count, tap counter and run_q live in the top module.

## Test plan
- Reset release with enable = 1:
  - in_ready is 0 in the first cycle and 1 from the second.
  - All other outputs are 0.
- Two back-to-back pairs at edges T-1 and T, out_ready = 1:
  - load_sel is 0 then 1.
  - shift_en is high at T+1.
  - 126 mac_en cycles occur, with acc_clr only at rom_addr 0.
  - out_valid is high only at T+129.
- out_ready held low for 10 cycles after out_valid:
  - out_valid stays high for 11 cycles and in_ready stays 0.
  - With the macro defined, stall_cnt = 10.
- mode_882 toggled at T+50 during a frame: use_882 is unchanged until the next S_SHIFT, then follows.
- enable dropped after the first pair, then raised 20 cycles later:
  - No shift_en occurs while enable is low.
  - The next handshake has load_sel = 1 and starts the frame.
- reset_n pulsed low at T+60: all outputs return to 0 asynchronously, and the next frame starts from a fill count of 0.
